// File: rtl/fb_rd_sched_if.sv
// Read-request bus between the frame-buffer read scheduler and the SDRAM controller / TFT read FIFO.
interface fb_rd_sched_if;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [9:0]  rd_len;
  logic        rd_ack;
  logic        rd_end;
  logic [10:0] rd_fifo_num;
  logic        fifo_flush;

  modport master (
    output rd_req, rd_addr, rd_len, fifo_flush,
    input  rd_ack, rd_end, rd_fifo_num
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, fifo_flush,
    output rd_ack, rd_end, rd_fifo_num
  );
endinterface

// File: rtl/fb_rd_sched.sv
// Read-side frame-buffer scheduler: keeps the TFT read FIFO fed with burst reads from the most
// recently completed camera bank, flushing at every display frame start and counting underruns.
module fb_rd_sched #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] BANK_SIZE   = 24'h080000,
  parameter logic [23:0] FRAME_WORDS = 24'd307200,
  parameter logic [9:0]  BURST_LEN   = 10'd256,
  parameter logic [10:0] FIFO_DEPTH  = 11'd1024,
  parameter logic [3:0]  FLUSH_CYC   = 4'd4
) (
  input  logic          clk_100m,
  input  logic          sys_rst,
  input  logic          frame_start,
  input  logic          wr_frame_done,
  input  logic          wr_bank,
  fb_rd_sched_if.master rd_bus,
  output logic          frame_active,
  output logic [7:0]    underrun_cnt
);

  typedef enum logic [2:0] {StIdle, StFlush, StWait, StReq, StBurst, StDone} state_e;

  localparam logic [10:0] FillLimit = FIFO_DEPTH - {1'b0, BURST_LEN};

  state_e      state_q;
  logic        have_frame_q;
  logic        latest_bank_q;
  logic        rd_bank_q;
  logic        pending_q;
  logic [23:0] offset_q;
  logic [3:0]  flush_cnt_q;
  logic        rd_req_q;
  logic [23:0] rd_addr_q;
  logic [9:0]  rd_len_q;
  logic        fifo_flush_q;

  logic [23:0] remain;
  logic [9:0]  next_len;
  logic [23:0] next_addr;
  logic        enter_flush;

  always_comb begin
    remain    = FRAME_WORDS - offset_q;
    next_len  = (remain < {14'd0, BURST_LEN}) ? remain[9:0] : BURST_LEN;
    next_addr = BASE_ADDR + (rd_bank_q ? BANK_SIZE : 24'd0) + offset_q;
  end

  // A restart requested during REQ/BURST is deferred until the in-flight burst has landed.
  always_comb begin
    enter_flush = 1'b0;
    case (state_q)
      StIdle:                  enter_flush = frame_start && (have_frame_q || wr_frame_done);
      StFlush, StWait, StDone: enter_flush = frame_start;
      StBurst:                 enter_flush = rd_bus.rd_end && (pending_q || frame_start);
      default:                 enter_flush = 1'b0;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      have_frame_q  <= 1'b0;
      latest_bank_q <= 1'b0;
      rd_bank_q     <= 1'b0;
      pending_q     <= 1'b0;
      offset_q      <= 24'd0;
      flush_cnt_q   <= 4'd0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= BASE_ADDR;
      rd_len_q      <= 10'd0;
      fifo_flush_q  <= 1'b0;
      frame_active  <= 1'b0;
      underrun_cnt  <= 8'd0;
    end else begin
      if (wr_frame_done) begin
        latest_bank_q <= wr_bank;
        have_frame_q  <= 1'b1;
      end
      if (frame_start) begin
        rd_bank_q <= wr_frame_done ? wr_bank : latest_bank_q;
        if (frame_active && (underrun_cnt != 8'hff)) begin
          underrun_cnt <= underrun_cnt + 8'd1;
        end
      end

      if (enter_flush) begin
        state_q      <= StFlush;
        fifo_flush_q <= 1'b1;
        flush_cnt_q  <= 4'd0;
        offset_q     <= 24'd0;
        frame_active <= 1'b1;
        pending_q    <= 1'b0;
      end else begin
        case (state_q)
          StFlush: begin
            if (flush_cnt_q == FLUSH_CYC - 4'd1) begin
              fifo_flush_q <= 1'b0;
              state_q      <= StWait;
            end else begin
              flush_cnt_q <= flush_cnt_q + 4'd1;
            end
          end
          StWait: begin
            if (rd_bus.rd_fifo_num <= FillLimit) begin
              rd_addr_q <= next_addr;
              rd_len_q  <= next_len;
              rd_req_q  <= 1'b1;
              state_q   <= StReq;
            end
          end
          StReq: begin
            if (frame_start) pending_q <= 1'b1;
            if (rd_bus.rd_ack) begin
              rd_req_q <= 1'b0;
              offset_q <= offset_q + {14'd0, rd_len_q};
              state_q  <= StBurst;
            end
          end
          StBurst: begin
            if (frame_start) pending_q <= 1'b1;
            if (rd_bus.rd_end) begin
              if (offset_q == FRAME_WORDS) begin
                frame_active <= 1'b0;
                state_q      <= StDone;
              end else begin
                state_q <= StWait;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_bus.rd_req     = rd_req_q;
  assign rd_bus.rd_addr    = rd_addr_q;
  assign rd_bus.rd_len     = rd_len_q;
  assign rd_bus.fifo_flush = fifo_flush_q;

endmodule

// File: tb/tb_fb_rd_sched.sv
// Bench for fb_rd_sched: directed frame sequences plus randomized restarts, checked against a
// frame-level model of bank selection, burst addressing and underrun counting.
module tb_fb_rd_sched;
  localparam logic [23:0] BASE = 24'h000000;
  localparam logic [23:0] BANK = 24'h080000;
  localparam int          FW   = 1000;
  localparam int          BL   = 256;

  logic       clk_100m = 1'b0;
  logic       sys_rst;
  logic       frame_start;
  logic       wr_frame_done;
  logic       wr_bank;
  logic       frame_active;
  logic [7:0] underrun_cnt;

  fb_rd_sched_if rd_bus ();

  int checks = 0;
  int failures = 0;

  // Frame-level reference model
  bit m_have = 1'b0;
  bit m_latest = 1'b0;
  bit m_bank = 1'b0;
  bit m_active = 1'b0;
  int m_off = 0;
  int exp_underrun = 0;

  always #5 clk_100m = ~clk_100m;

  fb_rd_sched #(
    .FRAME_WORDS (24'(FW))
  ) dut (
    .clk_100m      (clk_100m),
    .sys_rst       (sys_rst),
    .frame_start   (frame_start),
    .wr_frame_done (wr_frame_done),
    .wr_bank       (wr_bank),
    .rd_bus        (rd_bus),
    .frame_active  (frame_active),
    .underrun_cnt  (underrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic wfd_pulse(input bit wb);
    wr_frame_done = 1'b1;
    wr_bank       = wb;
    tick();
    wr_frame_done = 1'b0;
    m_latest      = wb;
    m_have        = 1'b1;
  endtask

  task automatic pulse_fs(input bit wfd, input bit wb);
    frame_start   = 1'b1;
    wr_frame_done = wfd;
    wr_bank       = wb;
    tick();
    frame_start   = 1'b0;
    wr_frame_done = 1'b0;
    if (m_active && exp_underrun < 255) exp_underrun++;
    if (wfd) begin
      m_latest = wb;
      m_have   = 1'b1;
    end
    if (m_have) begin
      m_active = 1'b1;
      m_bank   = m_latest;
      m_off    = 0;
    end
  endtask

  task automatic quiet_cycles(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      if (rd_bus.rd_req !== 1'b0 || rd_bus.fifo_flush !== 1'b0) bad++;
      tick();
    end
    check(tag, bad, 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (rd_bus.rd_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("req_seen", rd_bus.rd_req, 1);
  endtask

  task automatic check_flush(input int exp_n);
    int n = 0;
    int bad = 0;
    while (rd_bus.fifo_flush === 1'b1 && n < 40) begin
      if (rd_bus.rd_req !== 1'b0) bad++;
      n++;
      tick();
    end
    check("flush_len", n, exp_n);
    check("flush_no_req", bad, 0);
    check("underrun", underrun_cnt, exp_underrun);
  endtask

  // fs_where: 0 none, 1 frame_start while the request is pending, 2 during the burst
  task automatic issue_burst(input int fs_where, input bit wfd, input bit wb);
    int          len;
    int          unstable = 0;
    logic [23:0] exp_a;
    len   = (FW - m_off < BL) ? FW - m_off : BL;
    exp_a = BASE + (m_bank ? BANK : 24'd0) + 24'(m_off);
    wait_req();
    check("rd_addr", exp_a == rd_bus.rd_addr ? 32'(exp_a) : 32'(rd_bus.rd_addr), 32'(exp_a));
    check("rd_len", rd_bus.rd_len, len);
    check("active_in_req", frame_active, 1);
    m_off += len;
    repeat ($urandom_range(0, 3)) begin
      tick();
      if (rd_bus.rd_req !== 1'b1 || rd_bus.rd_addr !== exp_a || rd_bus.rd_len !== 10'(len))
        unstable++;
    end
    if (fs_where == 1) begin
      pulse_fs(wfd, wb);
      if (rd_bus.rd_req !== 1'b1 || rd_bus.rd_addr !== exp_a) unstable++;
    end
    check("req_stable", unstable, 0);
    rd_bus.rd_ack = 1'b1;
    tick();
    rd_bus.rd_ack = 1'b0;
    check("req_drop", rd_bus.rd_req, 0);
    repeat ($urandom_range(0, 4)) tick();
    if (fs_where == 2) pulse_fs(wfd, wb);
    rd_bus.rd_end = 1'b1;
    tick();
    rd_bus.rd_end = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst            = 1'b1;
    frame_start        = 1'b0;
    wr_frame_done      = 1'b0;
    wr_bank            = 1'b0;
    rd_bus.rd_ack      = 1'b0;
    rd_bus.rd_end      = 1'b0;
    rd_bus.rd_fifo_num = 11'd0;
    repeat (3) tick();
    check("rst_req", rd_bus.rd_req, 0);
    check("rst_addr", rd_bus.rd_addr, BASE);
    check("rst_len", rd_bus.rd_len, 0);
    check("rst_flush", rd_bus.fifo_flush, 0);
    check("rst_active", frame_active, 0);
    check("rst_underrun", underrun_cnt, 0);
    sys_rst = 1'b0;

    // No completed camera frame yet: must stay idle
    pulse_fs(1'b0, 1'b0);
    quiet_cycles(1000, "idle_quiet");
    check("idle_underrun", underrun_cnt, 0);

    // Bank 1 frame, FIFO empty
    wfd_pulse(1'b1);
    pulse_fs(1'b0, 1'b0);
    check_flush(4);
    issue_burst(0, 1'b0, 1'b0);
    issue_burst(0, 1'b0, 1'b0);

    // FIFO threshold: 900 and 769 block, 768 issues on the next cycle
    rd_bus.rd_fifo_num = 11'd900;
    quiet_cycles(10, "thresh_900");
    rd_bus.rd_fifo_num = 11'd769;
    quiet_cycles(10, "thresh_769");
    rd_bus.rd_fifo_num = 11'd768;
    tick();
    check("thresh_768_req", rd_bus.rd_req, 1);
    issue_burst(0, 1'b0, 1'b0);
    rd_bus.rd_fifo_num = 11'd0;
    issue_burst(0, 1'b0, 1'b0);
    m_active = 1'b0;
    check("done_inactive", frame_active, 0);
    quiet_cycles(50, "done_quiet");

    // Bank 0 full frame from DONE: no underrun
    wfd_pulse(1'b0);
    pulse_fs(1'b0, 1'b0);
    check_flush(4);
    repeat (4) issue_burst(0, 1'b0, 1'b0);
    m_active = 1'b0;
    check("done2_inactive", frame_active, 0);
    quiet_cycles(30, "done2_quiet");

    // Same-cycle completion of bank 0 beats latest_bank=1
    wfd_pulse(1'b1);
    pulse_fs(1'b1, 1'b0);
    check_flush(4);
    issue_burst(0, 1'b0, 1'b0);
    issue_burst(0, 1'b0, 1'b0);
    issue_burst(2, 1'b0, 1'b0);
    check_flush(4);
    issue_burst(0, 1'b0, 1'b0);

    // Restart from WAIT, then again inside FLUSH with a new bank latched
    pulse_fs(1'b0, 1'b0);
    tick();
    pulse_fs(1'b1, 1'b1);
    check_flush(4);

    // Randomized interrupted frames; counter must saturate
    for (int f = 0; f < 300; f++) begin
      int k;
      int where_fs;
      int bsel;
      bit nb;
      k        = int'($urandom_range(0, 3));
      where_fs = int'($urandom_range(1, 2));
      bsel     = int'($urandom_range(0, 2));
      nb       = 1'($urandom_range(0, 1));
      for (int b = 0; b < k; b++) issue_burst(0, 1'b0, 1'b0);
      if (bsel == 1) wfd_pulse(nb);
      issue_burst(where_fs, bsel == 2, nb);
      check_flush(4);
    end
    check("underrun_sat", underrun_cnt, 255);

    // Reset while a request is pending
    wait_req();
    sys_rst = 1'b1;
    tick();
    check("rst_req_drop", rd_bus.rd_req, 0);
    check("rst2_addr", rd_bus.rd_addr, BASE);
    check("rst2_underrun", underrun_cnt, 0);
    check("rst2_active", frame_active, 0);
    sys_rst      = 1'b0;
    m_have       = 1'b0;
    m_latest     = 1'b0;
    m_active     = 1'b0;
    exp_underrun = 0;
    pulse_fs(1'b0, 1'b0);
    quiet_cycles(30, "post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_rd_sched.md
Name: fb_rd_sched

Overview:
- Read-side scheduler for the SDRAM frame buffer that feeds the TFT display path.
- Runs in the SDRAM clock domain. Issues burst read requests so the TFT read FIFO stays filled for one 640x480 RGB565 frame per display frame.
- Picks the most recently completed camera bank (double buffering) at every display frame start, and flushes the FIFO at frame boundaries.
- Counts frames where the display started before the previous frame was fully fetched.

Parameters:
- BASE_ADDR, 24'h000000, SDRAM word address of bank 0.
- BANK_SIZE, 24'h080000, word offset between bank 0 and bank 1.
- FRAME_WORDS, 24'd307200, 16-bit words per frame (640*480).
- BURST_LEN, 10'd256, maximum words per read burst.
- FIFO_DEPTH, 11'd1024, read FIFO depth in words.
- FLUSH_CYC, 4'd4, cycles fifo_flush is held high.

Ports:
- clk_100m  in  1  SDRAM/system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse, display vsync start, already synchronised to clk_100m.
- wr_frame_done  in  1  one-cycle pulse, camera writer finished a frame.
- wr_bank  in  1  bank just completed; valid with wr_frame_done.
- rd_fifo_num  in  11  current read FIFO fill level (words).
- rd_ack  in  1  SDRAM controller accepted the request (one-cycle pulse).
- rd_end  in  1  last word of the accepted burst written to FIFO (one-cycle pulse).
- rd_req  out  1  burst read request.
- rd_addr  out  24  burst start word address.
- rd_len  out  10  burst length in words (1..BURST_LEN).
- fifo_flush  out  1  clear read FIFO.
- frame_active  out  1  current frame still has words to fetch.
- underrun_cnt  out  8  saturating count of incomplete frames.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - rd_req=0, rd_addr=BASE_ADDR, rd_len=0, fifo_flush=0, frame_active=0, underrun_cnt=0.
  - State IDLE, have_frame=0, latest_bank=0, rd_bank=0, offset=0, flush_cnt=0.
  - Reset mid-request or mid-burst drops rd_req at that edge and discards all pending state.
- Bank tracking:
  - On wr_frame_done, latest_bank<=wr_bank and have_frame<=1.
  - On frame_start, rd_bank<=(wr_frame_done ? wr_bank : latest_bank); the same-cycle completion wins.
- States:
  - IDLE: on frame_start with have_frame (or wr_frame_done in the same cycle) -> FLUSH. Otherwise stay in IDLE; no requests.
  - FLUSH: fifo_flush=1 for exactly FLUSH_CYC cycles; offset<=0; frame_active<=1; then -> WAIT.
  - WAIT: if rd_fifo_num <= FIFO_DEPTH-BURST_LEN, load the request and -> REQ the next cycle:
    - rd_addr = BASE_ADDR + (rd_bank ? BANK_SIZE : 0) + offset
    - rd_len = min(BURST_LEN, FRAME_WORDS-offset)
  - REQ: rd_req=1, with rd_addr/rd_len held stable until rd_ack. On rd_ack, rd_req<=0, offset<=offset+rd_len, -> BURST.
  - BURST: wait for rd_end. Then -> DONE if offset==FRAME_WORDS (frame_active<=0), else -> WAIT.
  - DONE: idle until frame_start -> FLUSH.
- frame_start handling:
  - In WAIT: -> FLUSH next cycle.
  - In REQ or BURST: set pending_restart. The request cannot be withdrawn; finish through rd_end, then -> FLUSH instead of WAIT/DONE.
  - In FLUSH: restart the FLUSH_CYC count; re-latch the bank.
- Underrun:
  - frame_start while frame_active=1 increments underrun_cnt, saturating at 255.
  - No increment from IDLE or DONE.
- Request rules:
  - At most one outstanding burst.
  - rd_req never asserts during FLUSH, IDLE or DONE.
  - A burst never crosses FRAME_WORDS.
- Widths:
  - Address sum is 24 bits; overflow wraps (parameters must keep the bank inside 24 bits).
  - FIFO threshold comparison is unsigned 11-bit.

Test Plan:
- Reset, frame_start with no prior wr_frame_done -> stays IDLE, rd_req and fifo_flush stay 0 for 1000 cycles.
- wr_frame_done(wr_bank=1), then frame_start, rd_fifo_num=0:
  - fifo_flush high exactly 4 cycles, then rd_req with rd_addr=24'h080000, rd_len=256.
  - After rd_ack/rd_end, next rd_addr=24'h080100.
- rd_fifo_num=900 in WAIT -> no rd_req. Lower it to 768 -> rd_req the following cycle, rd_len=256.
- FRAME_WORDS=1000 override, rd_bank=0 -> rd_len 256,256,256,232 at addresses 0,256,512,768; then frame_active=0, DONE, no further requests.
- frame_start mid-BURST at offset 512:
  - Burst completes through rd_end, underrun_cnt=1, fifo_flush pulse.
  - Next rd_addr at offset 0.
  - 300 such frames -> underrun_cnt=255.
- frame_start coincident with wr_frame_done(wr_bank=0) while latest_bank=1 -> first rd_addr=BASE_ADDR (bank 0). sys_rst during REQ -> rd_req=0 at that edge.
